// File: rtl/rom_port_responder_if.sv
// Multiplexed 4-bit instruction/data bus between the CPU and the ROM-side responders.
// busIn carries the resolved bus value, including whatever a responder is driving.
interface rom_port_responder_if;
    logic       sync;
    logic       cmRom;
    logic [3:0] busIn;
    logic [3:0] busOut;
    logic       busOe;

    modport master (
        output sync,
        output cmRom,
        output busIn,
        input  busOut,
        input  busOe
    );

    modport slave (
        input  sync,
        input  cmRom,
        input  busIn,
        output busOut,
        output busOe
    );
endinterface

// File: rtl/rom_port_responder.sv
// ROM-chip end of the 4-bit multiplexed bus: tracks the 8-phase machine cycle, returns the
// addressed instruction byte when chip-selected, and snoops every fetch to execute SRC/WRR/RDR
// against its own 4-bit I/O port.
module rom_port_responder #(
    parameter logic [3:0] CHIP_ID  = 4'h0,
    parameter logic [3:0] IO_RESET = 4'h0
) (
    input  logic                       clk,
    input  logic                       rstN,
    rom_port_responder_if.slave        bus,
    output logic [7:0]                 romAddr,
    input  logic [7:0]                 romData,
    input  logic [3:0]                 ioIn,
    output logic [3:0]                 ioOut,
    output logic [2:0]                 cycle,
    output logic                       selected,
    output logic                       srcSel
);

    typedef enum logic [2:0] {
        PhA1 = 3'd0,
        PhA2 = 3'd1,
        PhA3 = 3'd2,
        PhM1 = 3'd3,
        PhM2 = 3'd4,
        PhX1 = 3'd5,
        PhX2 = 3'd6,
        PhX3 = 3'd7
    } phase_e;

    phase_e     phaseQ, phaseD;
    logic       syncedQ, syncedD;
    logic [3:0] addrLoQ, addrLoD;
    logic [7:0] romAddrQ, romAddrD;
    logic       selectedQ, selectedD;
    logic [3:0] oprQ, oprD;
    logic [3:0] opaQ, opaD;
    logic       secondWordQ, secondWordD;
    logic       srcSelQ, srcSelD;
    logic [3:0] ioOutQ, ioOutD;
    logic       busOeQ, busOeD;
    logic [3:0] busOutQ, busOutD;

    logic chipHit;
    logic firstWord;
    logic isSrc;
    logic isWrr;
    logic isRdr;
    logic isTwoWord;

    assign chipHit   = (bus.busIn == CHIP_ID);
    assign firstWord = !secondWordQ;
    assign isSrc     = firstWord && (oprQ == 4'h2) && opaQ[0];
    assign isWrr     = firstWord && (oprQ == 4'hE) && (opaQ == 4'h2) && srcSelQ;
    assign isRdr     = firstWord && (oprQ == 4'hE) && (opaQ == 4'hA) && srcSelQ;
    // JCN, FIM, FIN, JUN, JMS, ISZ carry a second instruction byte in the following cycle.
    assign isTwoWord = (oprQ == 4'h1) ||
                       ((oprQ == 4'h2) && !opaQ[0]) ||
                       ((oprQ == 4'h3) && !opaQ[0]) ||
                       (oprQ == 4'h4) || (oprQ == 4'h5) || (oprQ == 4'h7);

    // Next-state: phase sequencing, address capture, snooping and registered bus drive.
    always_comb begin
        phaseD      = phaseQ;
        syncedD     = syncedQ;
        addrLoD     = addrLoQ;
        romAddrD    = romAddrQ;
        selectedD   = selectedQ;
        oprD        = oprQ;
        opaD        = opaQ;
        secondWordD = secondWordQ;
        srcSelD     = srcSelQ;
        ioOutD      = ioOutQ;
        busOeD      = 1'b0;
        busOutD     = 4'h0;
        if (bus.sync) begin
            // A new cycle starts; anything pending from an interrupted cycle is dropped.
            phaseD    = PhA1;
            syncedD   = 1'b1;
            selectedD = 1'b0;
        end else if (syncedQ) begin
            if (phaseQ != PhX3) begin
                phaseD = phase_e'(phaseQ + 3'd1);
            end
            unique case (phaseQ)
                PhA1: addrLoD = bus.busIn;
                PhA2: romAddrD = {bus.busIn, addrLoQ};
                PhA3: begin
                    selectedD = chipHit && bus.cmRom;
                    if (chipHit && bus.cmRom) begin
                        busOeD  = 1'b1;
                        busOutD = romData[7:4];
                    end
                end
                PhM1: begin
                    oprD = bus.busIn;
                    if (selectedQ) begin
                        busOeD  = 1'b1;
                        busOutD = romData[3:0];
                    end
                end
                PhM2: opaD = bus.busIn;
                PhX1: begin
                    // Port pins are sampled at the edge that opens X2.
                    if (isRdr) begin
                        busOeD  = 1'b1;
                        busOutD = ioIn;
                    end
                end
                PhX2: begin
                    if (isSrc && bus.cmRom) begin
                        srcSelD = chipHit;
                    end
                    if (isWrr) begin
                        ioOutD = bus.busIn;
                    end
                    secondWordD = firstWord && isTwoWord;
                end
                PhX3: ;
                default: ;
            endcase
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            phaseQ      <= PhX3;
            syncedQ     <= 1'b0;
            addrLoQ     <= 4'h0;
            romAddrQ    <= 8'h00;
            selectedQ   <= 1'b0;
            oprQ        <= 4'h0;
            opaQ        <= 4'h0;
            secondWordQ <= 1'b0;
            srcSelQ     <= 1'b0;
            ioOutQ      <= IO_RESET;
            busOeQ      <= 1'b0;
            busOutQ     <= 4'h0;
        end else begin
            phaseQ      <= phaseD;
            syncedQ     <= syncedD;
            addrLoQ     <= addrLoD;
            romAddrQ    <= romAddrD;
            selectedQ   <= selectedD;
            oprQ        <= oprD;
            opaQ        <= opaD;
            secondWordQ <= secondWordD;
            srcSelQ     <= srcSelD;
            ioOutQ      <= ioOutD;
            busOeQ      <= busOeD;
            busOutQ     <= busOutD;
        end
    end

    assign bus.busOut = busOutQ;
    assign bus.busOe  = busOeQ;
    assign romAddr    = romAddrQ;
    assign ioOut      = ioOutQ;
    assign cycle      = phaseQ;
    assign selected   = selectedQ;
    assign srcSel     = srcSelQ;

endmodule
